move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 48: gravity period in frames at level 0.
REQ-002 SHALL have parameter PERIOD_STEP, default 5: gravity period reduction per level.
REQ-003 SHALL have parameter MIN_PERIOD, default 3: lower bound on gravity period in frames.
REQ-004 SHALL have parameter DAS_FRAMES, default 6: auto-repeat interval in frames.
REQ-005 SHALL have port clock  in  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port vsync  in  1  frame sync from the VGA controller, asynchronous to frame logic.
REQ-008 SHALL have port actions  in  4  raw buttons: bit0 right, bit1 left, bit2 rotate, bit3 soft drop.
REQ-009 SHALL have port score  in  8  current score from the tetrimino engine.
REQ-010 SHALL have port op_ready  in  1  engine accepts the presented operation.
REQ-011 SHALL have port operation  out  4  one-hot op: bit0 right, bit1 left, bit2 rotate, bit3 down.
REQ-012 SHALL have port op_valid  out  1  operation is valid.
REQ-013 SHALL have port level  out  3  current level.
REQ-014 SHALL have port frame_count  out  11  frames since reset, wrapping modulo 2048.

Function
REQ-015 SHALL form frame_tick as a 1-cycle pulse on each vsync rising edge, through a 2-flop synchronizer plus edge detector; latency is 3 cycles from the vsync edge.
REQ-016 SHALL increment frame_count on each frame_tick.
REQ-017 SHALL compute level as min(score >> 3, 7), registered once per frame_tick.
REQ-018 SHALL compute the gravity period as max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD), evaluated with no underflow, using 7-bit unsigned arithmetic.
REQ-019 SHALL count frames in a gravity counter; when the count reaches period-1, it SHALL set pending_grav and clear to 0 on that same frame_tick.
REQ-020 SHALL sample actions on frame_tick; a 0->1 transition relative to the previous frame's sample SHALL set the matching pending bit.
REQ-021 SHALL make pending bits sticky until issued; a re-press of an already-pending bit is absorbed, with no duplicate operation.
REQ-022 SHALL issue the soft drop (bit3) and gravity both as operation bit3; if both are pending, one down is issued and both pending bits clear.
REQ-023 SHALL run a FSM with states IDLE, ISSUE and HOLD.
REQ-024 SHALL make IDLE->ISSUE when any pending bit is set and at least 1 cycle has passed since the last accept.
REQ-025 SHALL, in ISSUE, select the highest-priority pending op in the order rotate > left > right > down, drive operation one-hot with op_valid=1, and go to HOLD.
REQ-026 SHALL, in HOLD, keep operation and op_valid stable until op_ready=1; on the accepting cycle, clear that pending bit and go to IDLE.
REQ-027 SHALL set operation=0 whenever op_valid=0.
REQ-028 SHALL let a frame_tick during HOLD set further pending bits without disturbing the presented operation.
REQ-029 SHALL, if left and right are pending simultaneously, issue both, left first per priority.

Reset
REQ-030 SHALL, on reset, set operation=0, op_valid=0, level=0, frame_count=0, gravity counter=0, all pending bits=0, previous samples=0, synchronizer=0, FSM=IDLE.
REQ-031 SHALL let a reset asserted in HOLD drop op_valid on the next edge; the operation is discarded and not reissued.

Configuration
REQ-032 SHALL, with AUTOREPEAT_EN defined, re-set pending right/left every DAS_FRAMES frames while the button stays held, using a per-direction frame counter that clears on release.
REQ-033 SHALL, without AUTOREPEAT_EN, issue right/left on press edges only, and include no repeat counters.

Structure
REQ-034 SHALL put the op one-hot constants, the FSM state typedef and the level cap (7) in shared package tetris_pkg.
REQ-035 SHALL place the synchronizer and edge detector in sub-module frame_sync.

Verification
REQ-036 SHALL cover: reset, then 48 vsync pulses with no buttons -> exactly one down operation, frame_count=48.
REQ-037 SHALL cover: rotate and left pressed in the same frame, op_ready tied 1 -> rotate accepted, then left, each 1 cycle valid, pending empty afterwards.
REQ-038 SHALL cover: op_ready held 0 for 200 cycles across 2 vsync edges -> operation stable, op_valid stays 1, newly pressed right is issued after the accept.
REQ-039 SHALL cover: score=8'd200 -> level=7, gravity period=13; score=8'd16 -> level=2, period=38.
REQ-040 SHALL cover: right held for 20 frames -> 1 op without AUTOREPEAT_EN; 4 ops with it (frames 0,6,12,18).
REQ-041 SHALL cover: reset asserted while in HOLD -> op_valid=0 next cycle, the op is not reissued after reset release.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared constants for the move scheduler: one-hot operation codes, FSM state
// encoding, the level cap and the operation priority picker.
package tetris_pkg;

  localparam logic [3:0] OP_NONE   = 4'b0000;
  localparam logic [3:0] OP_RIGHT  = 4'b0001;
  localparam logic [3:0] OP_LEFT   = 4'b0010;
  localparam logic [3:0] OP_ROTATE = 4'b0100;
  localparam logic [3:0] OP_DOWN   = 4'b1000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

  localparam logic [2:0] LEVEL_CAP = 3'd7;

  // Pending vector uses the same bit layout as the one-hot operation codes.
  function automatic logic [3:0] pick_op(input logic [3:0] pend);
    logic [3:0] op;
    op = OP_NONE;
    if (pend[2])      op = OP_ROTATE;
    else if (pend[1]) op = OP_LEFT;
    else if (pend[0]) op = OP_RIGHT;
    else if (pend[3]) op = OP_DOWN;
    return op;
  endfunction

endpackage

// File: rtl/frame_sync.sv
// Brings the VGA vsync into the clock domain and emits a single-cycle
// frame_tick three cycles after each vsync rising edge.
module frame_sync (
  input  logic clock,
  input  logic reset,
  input  logic vsync,
  output logic frame_tick
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       tick_q, tick_d;

  always_comb begin
    sync_d = {sync_q[0], vsync};
    prev_d = sync_q[1];
    tick_d = sync_q[1] & ~prev_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/move_scheduler.sv
// Turns button presses and gravity into a stream of one-hot engine operations.
// Optional AUTOREPEAT_EN adds held-button repeat for right/left.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int BASE_PERIOD = 48,
  parameter int PERIOD_STEP = 5,
  parameter int MIN_PERIOD  = 3,
  parameter int DAS_FRAMES  = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vsync,
  input  logic [3:0]  actions,
  input  logic [7:0]  score,
  input  logic        op_ready,
  output logic [3:0]  operation,
  output logic        op_valid,
  output logic [2:0]  level,
  output logic [10:0] frame_count
);

  logic        frame_tick;
  logic [10:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]  level_q, level_d;
  logic [6:0]  grav_cnt_q, grav_cnt_d;
  logic        grav_pend_q, grav_pend_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  prev_act_q, prev_act_d;
  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        valid_q, valid_d;

  logic [7:0]  score_lvl;
  logic [6:0]  base7, min7, drop7, period;
  logic [3:0]  rise, rep_set, eff_pend;
  logic        accept;

  frame_sync u_frame_sync (
    .clock      (clock),
    .reset      (reset),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  assign score_lvl = score >> 3;
  assign rise      = actions & ~prev_act_q;
  assign eff_pend  = {pend_q[3] | grav_pend_q, pend_q[2:0]};
  assign accept    = (state_q == ST_HOLD) && op_ready;

  // Gravity period is clamped before it can underflow below MIN_PERIOD.
  always_comb begin
    base7  = 7'(BASE_PERIOD);
    min7   = 7'(MIN_PERIOD);
    drop7  = 7'(level_q) * 7'(PERIOD_STEP);
    period = ((base7 > drop7) && ((base7 - drop7) > min7)) ? (base7 - drop7) : min7;
  end

`ifdef AUTOREPEAT_EN
  localparam int REP_W = $clog2(DAS_FRAMES + 1);
  logic [1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;

  always_comb begin
    rep_set   = 4'b0000;
    rep_cnt_d = rep_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (frame_tick) begin
        if (!actions[i] || rise[i]) begin
          rep_cnt_d[i] = '0;
        end else if (rep_cnt_q[i] == REP_W'(DAS_FRAMES - 1)) begin
          rep_set[i]   = 1'b1;
          rep_cnt_d[i] = '0;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rep_cnt_q <= '0;
    else       rep_cnt_q <= rep_cnt_d;
  end
`else
  assign rep_set = 4'b0000;
`endif

  // Accept clears before a same-cycle frame tick sets, so no new event is lost.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    level_d     = level_q;
    grav_cnt_d  = grav_cnt_q;
    grav_pend_d = grav_pend_q;
    pend_d      = pend_q;
    prev_act_d  = prev_act_q;
    if (accept) begin
      pend_d = pend_d & ~op_q;
      if (op_q[3]) grav_pend_d = 1'b0;
    end
    if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + 11'd1;
      level_d     = (score_lvl > 8'(LEVEL_CAP)) ? LEVEL_CAP : score_lvl[2:0];
      prev_act_d  = actions;
      pend_d      = pend_d | rise | rep_set;
      if (grav_cnt_q >= period - 7'd1) begin
        grav_pend_d = 1'b1;
        grav_cnt_d  = 7'd0;
      end else begin
        grav_cnt_d  = grav_cnt_q + 7'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (|eff_pend) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        op_d    = pick_op(eff_pend);
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (op_ready) begin
          op_d    = OP_NONE;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        op_d    = OP_NONE;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= 11'd0;
      level_q     <= 3'd0;
      grav_cnt_q  <= 7'd0;
      grav_pend_q <= 1'b0;
      pend_q      <= 4'b0000;
      prev_act_q  <= 4'b0000;
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      valid_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      level_q     <= level_d;
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
      pend_q      <= pend_d;
      prev_act_q  <= prev_act_d;
      state_q     <= state_d;
      op_q        <= op_d;
      valid_q     <= valid_d;
    end
  end

  assign operation   = valid_q ? op_q : OP_NONE;
  assign op_valid    = valid_q;
  assign level       = level_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios, a score/level
// table and a randomized run against a frame-level reference model.
module tb_move_scheduler;

  localparam int FRAME_CYC = 30;
  localparam int DAS       = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic [3:0]  actions = 4'b0000;
  logic [7:0]  score = 8'd0;
  logic        op_ready = 1'b1;
  logic [3:0]  operation;
  logic        op_valid;
  logic [2:0]  level;
  logic [10:0] frame_count;

  int checks = 0;
  int fails  = 0;

  logic [3:0] acc_ops[$];
  int         acc_frames[$];
  int         valid_cycles = 0;

  typedef struct {
    logic [7:0] score;
    int         exp_level;
    int         exp_period;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  move_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .vsync       (vsync),
    .actions     (actions),
    .score       (score),
    .op_ready    (op_ready),
    .operation   (operation),
    .op_valid    (op_valid),
    .level       (level),
    .frame_count (frame_count)
  );

  // Record every accepted operation and every valid cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (op_valid) valid_cycles <= valid_cycles + 1;
      if (op_valid && op_ready) begin
        acc_ops.push_back(operation);
        acc_frames.push_back(int'(frame_count));
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset   = 1'b1;
    actions = 4'b0000;
    score   = 8'd0;
    vsync   = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulseFrame();
    vsync = 1'b1;
    repeat (4) @(negedge clock);
    vsync = 1'b0;
    repeat (FRAME_CYC - 4) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [3:0] act, input logic [7:0] sc, input int nframes);
    actions = act;
    score   = sc;
    repeat (nframes) pulseFrame();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mark, vmark, bad, nright;
    logic [3:0] exp_ops[$];

    vecs[0] = '{8'd0,   0, 48};
    vecs[1] = '{8'd8,   1, 43};
    vecs[2] = '{8'd16,  2, 38};
    vecs[3] = '{8'd40,  5, 23};
    vecs[4] = '{8'd55,  6, 18};
    vecs[5] = '{8'd56,  7, 13};
    vecs[6] = '{8'd200, 7, 13};
    vecs[7] = '{8'd255, 7, 13};

    // Reset state
    doReset();
    checkOutput("rst_valid", op_valid, 0);
    checkOutput("rst_op", operation, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_frames", frame_count, 0);

    // 48 idle frames give exactly one gravity down
    doReset();
    op_ready = 1'b1;
    mark = acc_ops.size();
    applyStimulus(4'b0000, 8'd0, 48);
    checkOutput("grav48_count", acc_ops.size() - mark, 1);
    if (acc_ops.size() > mark) checkOutput("grav48_op", acc_ops[mark], 8);
    checkOutput("grav48_frames", frame_count, 48);

    // Rotate and left in the same frame
    doReset();
    mark  = acc_ops.size();
    vmark = valid_cycles;
    applyStimulus(4'b0110, 8'd0, 1);
    applyStimulus(4'b0000, 8'd0, 1);
    checkOutput("prio_count", acc_ops.size() - mark, 2);
    if (acc_ops.size() >= mark + 2) begin
      checkOutput("prio_first", acc_ops[mark], 4);
      checkOutput("prio_second", acc_ops[mark + 1], 2);
    end
    checkOutput("prio_valid_cycles", valid_cycles - vmark, 2);
    checkOutput("prio_idle_after", op_valid, 0);

    // Engine stalls for 200 cycles across two frames
    doReset();
    op_ready = 1'b0;
    mark = acc_ops.size();
    applyStimulus(4'b0100, 8'd0, 1);
    checkOutput("stall_valid", op_valid, 1);
    checkOutput("stall_op", operation, 4);
    actions = 4'b0001;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      vsync = ((i >= 20 && i < 24) || (i >= 120 && i < 124));
      if (operation != 4'b0100 || !op_valid) bad++;
    end
    checkOutput("stall_stable_errors", bad, 0);
    op_ready = 1'b1;
    repeat (20) @(negedge clock);
    checkOutput("stall_count", acc_ops.size() - mark, 2);
    if (acc_ops.size() >= mark + 2) begin
      checkOutput("stall_first", acc_ops[mark], 4);
      checkOutput("stall_second", acc_ops[mark + 1], 1);
    end

    // Level and gravity period from score, measured between two downs
    foreach (vecs[r]) begin
      doReset();
      op_ready = 1'b1;
      mark = acc_ops.size();
      applyStimulus(4'b0000, vecs[r].score, 2 * vecs[r].exp_period + 1);
      checkOutput($sformatf("level_s%0d", vecs[r].score), level, vecs[r].exp_level);
      checkOutput($sformatf("period_s%0d", vecs[r].score),
                  (acc_frames.size() >= mark + 2) ? acc_frames[mark + 1] - acc_frames[mark] : -1,
                  vecs[r].exp_period);
    end

    // Right held for 20 frames
    doReset();
    mark = acc_ops.size();
    applyStimulus(4'b0001, 8'd0, 20);
    applyStimulus(4'b0000, 8'd0, 1);
    nright = 0;
    for (int i = mark; i < acc_ops.size(); i++) if (acc_ops[i] == 4'b0001) nright++;
`ifdef AUTOREPEAT_EN
    checkOutput("hold_right_ops", nright, 4);
`else
    checkOutput("hold_right_ops", nright, 1);
`endif
    checkOutput("hold_right_total", acc_ops.size() - mark, nright);

    // Reset while an operation is held
    doReset();
    op_ready = 1'b0;
    applyStimulus(4'b0100, 8'd0, 1);
    checkOutput("hold_rst_pre_valid", op_valid, 1);
    actions = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("hold_rst_valid", op_valid, 0);
    checkOutput("hold_rst_op", operation, 0);
    @(negedge clock);
    reset    = 1'b0;
    op_ready = 1'b1;
    mark = acc_ops.size();
    applyStimulus(4'b0000, 8'd0, 3);
    checkOutput("hold_rst_no_reissue", acc_ops.size() - mark, 0);

    // Randomized frames against a frame-level reference model
    doReset();
    op_ready = 1'b1;
    mark = acc_ops.size();
    begin
      logic [3:0] cur_act, m_prev, rise, pend;
      logic [7:0] cur_score;
      int m_level, m_cnt, period;
      bit grav;
`ifdef AUTOREPEAT_EN
      int held[2];
      held[0] = 0;
      held[1] = 0;
`endif
      cur_act = 4'b0000;
      cur_score = 8'd0;
      m_prev = 4'b0000;
      m_level = 0;
      m_cnt = 0;
      for (int f = 0; f < 80; f++) begin
        if ($urandom_range(0, 2) != 0) cur_act = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) cur_score = 8'($urandom_range(0, 255));
        applyStimulus(cur_act, cur_score, 1);
        period = 48 - m_level * 5;
        if (period < 3) period = 3;
        grav = 1'b0;
        if (m_cnt >= period - 1) begin
          grav = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
        rise = cur_act & ~m_prev;
        m_prev = cur_act;
        pend = rise;
`ifdef AUTOREPEAT_EN
        for (int d = 0; d < 2; d++) begin
          held[d] = cur_act[d] ? held[d] + 1 : 0;
          if (cur_act[d] && ((held[d] - 1) % DAS == 0)) pend[d] = 1'b1;
        end
`endif
        m_level = int'(cur_score) / 8;
        if (m_level > 7) m_level = 7;
        if (pend[2]) exp_ops.push_back(4'b0100);
        if (pend[1]) exp_ops.push_back(4'b0010);
        if (pend[0]) exp_ops.push_back(4'b0001);
        if (pend[3] || grav) exp_ops.push_back(4'b1000);
      end
    end
    checkOutput("rand_count", acc_ops.size() - mark, exp_ops.size());
    for (int i = 0; i < exp_ops.size() && (mark + i) < acc_ops.size(); i++)
      checkOutput($sformatf("rand_op%0d", i), acc_ops[mark + i], exp_ops[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
